// File: rtl/shift_pkg.sv
// Shared definitions for the serial shift link: bit-order encoding and receive FSM states.
package shift_pkg;

  localparam logic DIR_MSB_FIRST = 1'b0;
  localparam logic DIR_LSB_FIRST = 1'b1;

  typedef enum logic [0:0] {
    IDLE,
    RECV
  } rx_state_t;

endpackage

// File: rtl/shift_deser.sv
// Serial-to-parallel receiver: assembles WIDTH-bit words MSB- or LSB-first into a
// one-word holding register with valid/ready handshake, framing resync and sticky overrun.
module shift_deser
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin_valid,
  input  logic             sin,
  input  logic             frame,
  input  logic             dir,
  output logic [WIDTH-1:0] par_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overrun,
  input  logic             clr_ovr
);

  rx_state_t        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             dir_q;
  logic [WIDTH-1:0] sh_q;

  logic             start;
  logic             dir_eff;
  logic [CNT_W-1:0] cnt_eff;
  logic [WIDTH-1:0] sh_nxt;
  logic             done;
  logic             pop;

  // A framed bit or the first bit after IDLE becomes bit 0 and re-latches dir.
  always_comb begin
    start   = frame || (state_q == IDLE);
    dir_eff = start ? dir : dir_q;
    cnt_eff = start ? '0 : cnt_q;
    sh_nxt  = (dir_eff == DIR_LSB_FIRST) ? {sin, sh_q[WIDTH-1:1]} : {sh_q[WIDTH-2:0], sin};
    done    = sin_valid && (cnt_eff == CNT_W'(WIDTH - 1));
    pop     = out_valid && out_ready;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dir_q     <= DIR_MSB_FIRST;
      sh_q      <= '0;
      par_out   <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (sin_valid) begin
        sh_q  <= sh_nxt;
        dir_q <= dir_eff;
        if (done) begin
          cnt_q   <= '0;
          state_q <= IDLE;
          busy    <= 1'b0;
        end else begin
          cnt_q   <= cnt_eff + CNT_W'(1);
          state_q <= RECV;
          busy    <= 1'b1;
        end
      end

      // A pop on the completion edge frees the slot, so the new word loads without a bubble.
      if (done && (!out_valid || out_ready)) begin
        par_out   <= sh_nxt;
        out_valid <= 1'b1;
      end else if (pop) begin
        out_valid <= 1'b0;
      end

      if (done && out_valid && !out_ready) begin
        overrun <= 1'b1;
      end else if (clr_ovr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_shift_deser.sv
// Directed self-checking bench for shift_deser (WIDTH=4).
module tb_shift_deser;

  localparam int unsigned WIDTH = 4;

  logic             clk;
  logic             rst;
  logic             sin_valid;
  logic             sin;
  logic             frame;
  logic             dir;
  logic [WIDTH-1:0] par_out;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             overrun;
  logic             clr_ovr;

  int n_cmp;
  int n_err;

  shift_deser #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .sin_valid (sin_valid),
    .sin       (sin),
    .frame     (frame),
    .dir       (dir),
    .par_out   (par_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .overrun   (overrun),
    .clr_ovr   (clr_ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one valid bit from a falling edge to the next; returns just after outputs update.
  task automatic send_bit(input logic b, input logic d, input logic f);
    sin_valid = 1'b1;
    sin       = b;
    dir       = d;
    frame     = f;
    @(negedge clk);
    sin_valid = 1'b0;
    frame     = 1'b0;
  endtask

  task automatic send_word(input logic [3:0] bits, input logic d);
    for (int i = 3; i >= 0; i--) send_bit(bits[i], d, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst       = 1'b0;
    sin_valid = 1'b0;
    sin       = 1'b0;
    frame     = 1'b0;
    dir       = 1'b0;
    out_ready = 1'b1;
    clr_ovr   = 1'b0;
    idle(2);
    check("rst_par", par_out, 0);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_ovr", overrun, 0);
    rst = 1'b1;
    idle(1);

    // 1. MSB-first 1,0,1,1
    send_bit(1, 0, 0);
    check("t1_busy_b1", busy, 1);
    send_bit(0, 0, 0);
    send_bit(1, 0, 0);
    check("t1_busy_b3", busy, 1);
    check("t1_valid_early", out_valid, 0);
    send_bit(1, 0, 0);
    check("t1_valid", out_valid, 1);
    check("t1_par", par_out, 4'b1011);
    check("t1_busy_done", busy, 0);
    idle(1);
    check("t1_popped", out_valid, 0);

    // 2. LSB-first, then back-to-back words with dir change
    send_word(4'b1011, 1);
    check("t2_lsb_valid", out_valid, 1);
    check("t2_lsb_par", par_out, 4'b1101);
    idle(1);
    send_word(4'b0110, 0);
    check("t2_w1_valid", out_valid, 1);
    check("t2_w1_par", par_out, 4'b0110);
    send_bit(1, 1, 0);
    check("t2_w2_busy", busy, 1);
    send_bit(1, 1, 0);
    send_bit(0, 1, 0);
    send_bit(0, 1, 0);
    check("t2_w2_valid", out_valid, 1);
    check("t2_w2_par", par_out, 4'b0011);
    idle(1);

    // 3. Gapped input 1,1,0,1 MSB-first
    send_bit(1, 0, 0);
    idle(3);
    check("t3_busy_gap1", busy, 1);
    send_bit(1, 0, 0);
    idle(3);
    send_bit(0, 0, 0);
    idle(3);
    check("t3_busy_gap3", busy, 1);
    check("t3_valid_early", out_valid, 0);
    send_bit(1, 0, 0);
    check("t3_valid", out_valid, 1);
    check("t3_par", par_out, 4'b1101);
    idle(1);

    // 4. Backpressure, overrun, clear, and clear-vs-set
    out_ready = 1'b0;
    send_word(4'b1010, 0);
    check("t4_w1_valid", out_valid, 1);
    check("t4_ovr_before", overrun, 0);
    send_word(4'b0101, 0);
    check("t4_par_held", par_out, 4'b1010);
    check("t4_ovr_set", overrun, 1);
    out_ready = 1'b1;
    idle(1);
    out_ready = 1'b0;
    check("t4_popped", out_valid, 0);
    check("t4_par_kept", par_out, 4'b1010);
    clr_ovr = 1'b1;
    idle(1);
    clr_ovr = 1'b0;
    check("t4_ovr_clr", overrun, 0);
    send_word(4'b1111, 0);
    check("t4_w3_par", par_out, 4'b1111);
    send_bit(0, 0, 0);
    send_bit(0, 0, 0);
    send_bit(0, 0, 0);
    clr_ovr = 1'b1;
    send_bit(0, 0, 0);
    clr_ovr = 1'b0;
    check("t4_set_wins", overrun, 1);
    check("t4_par_unchg", par_out, 4'b1111);
    // Completion and pop on the same edge
    send_bit(1, 0, 0);
    send_bit(1, 0, 0);
    send_bit(0, 0, 0);
    out_ready = 1'b1;
    send_bit(0, 0, 0);
    check("t4_b2b_valid", out_valid, 1);
    check("t4_b2b_par", par_out, 4'b1100);
    clr_ovr = 1'b1;
    idle(1);
    clr_ovr = 1'b0;
    check("t4_b2b_popped", out_valid, 0);
    check("t4_ovr_clr2", overrun, 0);

    // 5. Resync via frame
    send_bit(1, 0, 0);
    send_bit(1, 0, 0);
    send_bit(0, 0, 1);
    check("t5_busy_frame", busy, 1);
    send_bit(0, 0, 0);
    send_bit(1, 0, 0);
    check("t5_valid_early", out_valid, 0);
    send_bit(0, 0, 0);
    check("t5_valid", out_valid, 1);
    check("t5_par", par_out, 4'b0010);
    check("t5_ovr", overrun, 0);
    idle(1);

    // 6. Async reset mid-word with a held word and overrun pending
    out_ready = 1'b0;
    send_word(4'b1011, 0);
    send_word(4'b0000, 0);
    send_bit(1, 0, 0);
    send_bit(0, 0, 0);
    check("t6_pre_valid", out_valid, 1);
    check("t6_pre_ovr", overrun, 1);
    #2 rst = 1'b0;
    #1;
    check("t6_rst_par", par_out, 0);
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_ovr", overrun, 0);
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    idle(1);
    send_word(4'b1001, 0);
    check("t6_valid", out_valid, 1);
    check("t6_par", par_out, 4'b1001);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/shift_deser.md
Name: shift_deser

Overview:
- Serial-to-parallel receiver at the far end of a serial shift link: the parallel-load shift/rotate registers shift words out, and this block reassembles them.
- It accumulates WIDTH serial bits, MSB-first or LSB-first per word, into a parallel word.
- Completed words go to a one-word output holding register with a valid/ready handshake.
- It provides framing resync, a busy indication and a sticky overrun flag.

Parameters:
- WIDTH, 4: word width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH): width of the bit counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset. Clears all state immediately on assertion; release is synchronous to clk.
- sin_valid  in  1  sin carries a valid bit this cycle.
- sin  in  1  serial data bit.
- frame  in  1  qualified by sin_valid: this bit is bit 0 of a new word.
- dir  in  1  bit order. 0 = MSB-first (shift left), 1 = LSB-first (shift right). Sampled with the first bit of each word.
- par_out  out  WIDTH  assembled word, stable while out_valid=1.
- out_valid  out  1  par_out holds an unconsumed word.
- out_ready  in  1  consumer accepts par_out when out_valid=1 and out_ready=1.
- busy  out  1  a partial word is in progress (bit counter != 0).
- overrun  out  1  sticky: a completed word was dropped.
- clr_ovr  in  1  synchronous clear of overrun.

Behaviour:
- Reset values: par_out=0, out_valid=0, busy=0, overrun=0. Shift register, bit counter and latched dir are also 0.
- Reset mid-word discards the partial word and any held word.
- Receive FSM states:
  - IDLE: cnt=0. On sin_valid -> RECV; this bit is bit 0 and dir is latched.
  - RECV: advances only on sin_valid; stalls hold state.
- frame: sin_valid=1 with frame=1 restarts the word in any state. cnt is forced so this bit is bit 0, dir is re-latched, and the partial word is silently discarded with no overrun. frame with sin_valid=0 is ignored.
- Shift rules, applied on each accepted bit:
  - MSB-first: sh <= {sh[WIDTH-2:0], sin}.
  - LSB-first: sh <= {sin, sh[WIDTH-1:1]}.
  - First-bit state is irrelevant because all WIDTH positions are overwritten.
- Completion: on the bit where cnt==WIDTH-1, the word including this bit is complete. cnt wraps to 0 and the FSM returns to IDLE.
- Completed word transfer:
  - If the holding register is empty, or is popped on the same edge (out_valid & out_ready), the word loads into par_out. out_valid is 1 from the next cycle, giving 1-cycle latency from the last bit's edge.
  - Otherwise the new word is dropped, par_out is unchanged, and overrun is set.
- Pop: out_valid & out_ready with no simultaneous completion -> out_valid=0 next cycle. par_out keeps its last value.
- Back-to-back: a completion and a pop on the same edge keep out_valid=1 with the new word; no bubble.
- overrun: set and clr_ovr on the same edge -> set wins.
- busy = (cnt != 0), registered. Consecutive words with sin_valid held high run with no idle cycle; dir may change at each word boundary.
- sin, frame and dir are don't-care when sin_valid=0.

Decomposition:
- Shared package shift_pkg:
  - DIR_MSB_FIRST=1'b0, DIR_LSB_FIRST=1'b1.
  - rx_state_t enum {IDLE, RECV}.
  - The package is reused by the shift-register blocks' sel decoding.
- Single module; no sub-module is warranted.
- Bit counter, shift register and holding register stay together in shift_deser.

Test Plan (WIDTH=4):
1. MSB-first: dir=0, bits 1,0,1,1 on consecutive cycles, out_ready=1 -> par_out=4'b1011, out_valid high exactly one cycle after the 4th bit's edge. busy=1 during bits 2-4, then 0.
2. LSB-first: dir=1, bits 1,0,1,1 -> par_out=4'b1101. Then 8 back-to-back bits, dir=0 for 0,1,1,0 and dir=1 for 1,1,0,0 -> words 4'b0110 then 4'b0011 on consecutive out_valid cycles, no bubble.
3. Gapped input: bits 1,1,0,1 with sin_valid low 3 cycles between each, dir=0 -> par_out=4'b1101. busy stays 1 through the gaps; out_valid does not rise early.
4. Backpressure: out_ready=0, send 4'b1010 then 4'b0101 -> par_out stays 4'b1010, overrun=1. Then out_ready=1 -> pop, out_valid=0. Pulse clr_ovr -> overrun=0. clr_ovr coincident with a new drop -> overrun stays 1.
5. Resync: dir=0, send bits 1,1, then frame=1 with bits 0,0,1,0 -> par_out=4'b0010, no overrun.
6. Async reset: assert rst=0 mid-word (after 2 bits) and while out_valid=1, between clock edges -> all outputs 0 immediately. After release, send 1,0,0,1 with dir=0 -> par_out=4'b1001.
